// File: rtl/wide_add_seq.sv
// ----------------------------------------------------------------------------
// wide_add_seq
//
// Multi-cycle wide adder. Two W = WIDTH*WORDS bit operands are added by
// reusing a single WIDTH-bit ripple-carry slice over WORDS cycles, least
// significant slice first. The carry between slices is held in a register.
//
// Optional feature: define WIDE_ADD_SEQ_OVERFLOW_EN to add overflow_out, the
// two's-complement signed overflow of the full W-bit add.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  operands and carry_in are valid
//   start_ready  block can accept an operation (high only in IDLE)
//   a_in, b_in   W-bit operands, sampled on the accepting edge
//   carry_in     carry into slice 0, sampled on the accepting edge
//   res_valid    result available (high only in DONE)
//   res_ready    consumer accepts the result
//   sum_out      registered W-bit sum
//   carry_out    registered carry out of the top slice
//   overflow_out signed overflow (only with WIDE_ADD_SEQ_OVERFLOW_EN)
// ----------------------------------------------------------------------------
module wide_add_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [WIDTH*WORDS-1:0] a_in,
   input  logic [WIDTH*WORDS-1:0] b_in,
   input  logic                   carry_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH*WORDS-1:0] sum_out,
   output logic                   carry_out
`ifdef WIDE_ADD_SEQ_OVERFLOW_EN
   ,
   output logic                   overflow_out
`endif
);

   // Index is at least one bit wide so WORDS=1 still has a legal register.
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e state_q, state_d;

   // Operands and sum are stored as word arrays so a slice is a plain index.
   logic [WORDS-1:0][WIDTH-1:0] a_q;
   logic [WORDS-1:0][WIDTH-1:0] b_q;
   logic [WORDS-1:0][WIDTH-1:0] sum_q;
   logic [IDX_W-1:0]            idx_q;
   logic                        carry_q;
   logic                        cout_q;

   logic             accept;
   logic             run_step;
   logic             last_step;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic [WIDTH-1:0] slice_sum;
   logic [WIDTH:0]   slice_c;

`ifdef WIDE_ADD_SEQ_OVERFLOW_EN
   logic ovf_q;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_valid) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (idx_q == LAST_IDX) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs and datapath strobes
   // -------------------------------------------------------------------------
   always_comb begin
      start_ready = 1'b0;
      res_valid   = 1'b0;
      accept      = 1'b0;
      run_step    = 1'b0;
      last_step   = 1'b0;
      unique case (state_q)
         StIdle: begin
            start_ready = 1'b1;
            accept      = start_valid;
         end
         StRun: begin
            run_step  = 1'b1;
            last_step = (idx_q == LAST_IDX);
         end
         StDone: begin
            res_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Single WIDTH-bit ripple-carry slice
   // -------------------------------------------------------------------------
   assign a_word = a_q[idx_q];
   assign b_word = b_q[idx_q];

   always_comb begin
      slice_c    = '0;
      slice_sum  = '0;
      slice_c[0] = carry_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         slice_sum[i]  = a_word[i] ^ b_word[i] ^ slice_c[i];
         slice_c[i+1]  = (a_word[i] & b_word[i]) | (slice_c[i] & (a_word[i] ^ b_word[i]));
      end
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= a_in;
         b_q     <= b_in;
         carry_q <= carry_in;
         idx_q   <= '0;
      end else if (run_step) begin
         carry_q <= slice_c[WIDTH];
         // Index wraps back to 0 after the last slice; it is cleared on the
         // next accept anyway.
         idx_q   <= last_step ? '0 : idx_q + 1'b1;
      end
   end

   // Result registers only change while RUN, so they hold through DONE for
   // any amount of backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (run_step) begin
         sum_q[idx_q] <= slice_sum;
         if (last_step) begin
            cout_q <= slice_c[WIDTH];
         end
      end
   end

`ifdef WIDE_ADD_SEQ_OVERFLOW_EN
   // Signed overflow: carry into the MSB differs from carry out of the MSB.
   // On the last step the slice MSB is the MSB of the full word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (run_step && last_step) begin
         ovf_q <= slice_c[WIDTH] ^ slice_c[WIDTH-1];
      end
   end

   assign overflow_out = ovf_q;
`endif

   assign sum_out   = sum_q;
   assign carry_out = cout_q;

endmodule
